// File: rtl/msrv32_timer_pkg.sv
// Shared definitions for the msrv32 machine timer: register offsets,
// reset values and the byte-masked store merge used by every register.
package msrv32_timer_pkg;

  // Byte offsets within the 32-byte register window
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;

  // mtimecmp resets to all-ones so no interrupt fires before software arms it
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  // Timer counts out of reset (enable=1, div=0)
  localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

  // Expand a 4-bit byte mask into a 32-bit bit mask
  function automatic logic [31:0] mask_bits(input logic [3:0] mask);
    logic [31:0] bits;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

  // Replace only the enabled bytes of a word with store data
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  mask);
    logic [31:0] bits;
    bits = mask_bits(mask);
    return (old_word & ~bits) | (wdata & bits);
  endfunction

endpackage

// File: rtl/msrv32_timer_prescaler.sv
// Prescaler for the machine timer: emits one tick every div+1 enabled cycles.
module msrv32_timer_prescaler
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_reg;

  // Tick in the cycle the counter matches the divide value
  assign tick = enable && (count_reg == div);

  // Count while enabled, wrap on tick, restart whenever div is rewritten
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/msrv32_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled counting,
// byte-masked stores, 1-cycle registered reads and a registered interrupt.
module msrv32_timer
  import msrv32_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic        dmwr_req_in,
  input  logic [3:0]  dmwr_mask_in,
  output logic [31:0] rdata_out,
  output logic        sel_out,
  output logic [63:0] real_time_out,
  output logic        tirq_out
);

  // Bits of the ctrl word that actually hold state
  localparam logic [31:0] DIV_FIELD   = ((32'd1 << PRESCALE_W) - 32'd1) << 8;
  localparam logic [31:0] CTRL_FIELDS = DIV_FIELD | 32'd1;

  logic                  hit;
  logic                  wr_en;
  logic [4:0]            word_off;
  logic [31:0]           wmask_bits;
  logic [63:0]           mtime_reg, mtime_next;
  logic [63:0]           mtimecmp_reg, mtimecmp_next;
  logic                  enable_reg, enable_next;
  logic [PRESCALE_W-1:0] div_reg, div_next;
  logic                  div_clear;
  logic                  tick;
  logic [31:0]           ctrl_word, ctrl_merged, rd_mux;
  logic [31:0]           rdata_reg;
  logic                  sel_reg, tirq_reg;
  logic                  unused_bits;

  assign hit        = (dmaddr_in[31:5] == BASE_ADDR[31:5]);
  assign word_off   = {dmaddr_in[4:2], 2'b00};
  assign wr_en      = hit && dmwr_req_in;
  assign wmask_bits = mask_bits(dmwr_mask_in);

  // Low address bits and non-field ctrl bits carry no state
  assign unused_bits = ^{dmaddr_in[1:0], ctrl_merged & ~CTRL_FIELDS};

  msrv32_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .enable  (enable_reg),
    .div     (div_reg),
    .clear   (div_clear),
    .tick    (tick)
  );

  // Assemble the ctrl word as software sees it
  always_comb begin
    ctrl_word                   = '0;
    ctrl_word[0]                = enable_reg;
    ctrl_word[8 +: PRESCALE_W]  = div_reg;
  end

  assign ctrl_merged = merge_bytes(ctrl_word, dmdata_in, dmwr_mask_in);

  // Next register state: a store to either mtime word overrides that cycle's tick
  always_comb begin
    mtime_next    = tick ? mtime_reg + 64'd1 : mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    enable_next   = enable_reg;
    div_next      = div_reg;
    div_clear     = 1'b0;
    if (wr_en) begin
      case (word_off)
        OFF_MTIME_LO:
          mtime_next = {mtime_reg[63:32],
                        merge_bytes(mtime_reg[31:0], dmdata_in, dmwr_mask_in)};
        OFF_MTIME_HI:
          mtime_next = {merge_bytes(mtime_reg[63:32], dmdata_in, dmwr_mask_in),
                        mtime_reg[31:0]};
        OFF_MTIMECMP_LO:
          mtimecmp_next = {mtimecmp_reg[63:32],
                           merge_bytes(mtimecmp_reg[31:0], dmdata_in, dmwr_mask_in)};
        OFF_MTIMECMP_HI:
          mtimecmp_next = {merge_bytes(mtimecmp_reg[63:32], dmdata_in, dmwr_mask_in),
                           mtimecmp_reg[31:0]};
        OFF_CTRL: begin
          enable_next = ctrl_merged[0];
          div_next    = ctrl_merged[8 +: PRESCALE_W];
          div_clear   = |(wmask_bits & DIV_FIELD);
        end
        default: ;
      endcase
    end
  end

  // Read mux over current (pre-write) register values; reserved words read 0
  always_comb begin
    case (word_off)
      OFF_MTIME_LO:    rd_mux = mtime_reg[31:0];
      OFF_MTIME_HI:    rd_mux = mtime_reg[63:32];
      OFF_MTIMECMP_LO: rd_mux = mtimecmp_reg[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp_reg[63:32];
      OFF_CTRL:        rd_mux = ctrl_word;
      default:         rd_mux = '0;
    endcase
  end

  // Register update, registered read port and registered interrupt compare
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= MTIMECMP_RST;
      enable_reg   <= CTRL_RST[0];
      div_reg      <= CTRL_RST[8 +: PRESCALE_W];
      rdata_reg    <= '0;
      sel_reg      <= 1'b0;
      tirq_reg     <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      enable_reg   <= enable_next;
      div_reg      <= div_next;
      rdata_reg    <= hit ? rd_mux : '0;
      sel_reg      <= hit;
      tirq_reg     <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign rdata_out     = rdata_reg;
  assign sel_out       = sel_reg;
  assign real_time_out = mtime_reg;
  assign tirq_out      = tirq_reg;

endmodule

// File: tb/tb_msrv32_timer.sv
// Self-checking bench for msrv32_timer: directed bus transactions with a
// read scoreboard plus direct checks of mtime and the interrupt output.
module tb_msrv32_timer;

  localparam logic [31:0] BASE      = 32'h0200_0000;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] dmaddr_in = IDLE_ADDR;
  logic [31:0] dmdata_in = '0;
  logic        dmwr_req_in = 1'b0;
  logic [3:0]  dmwr_mask_in = '0;
  logic [31:0] rdata_out;
  logic        sel_out;
  logic [63:0] real_time_out;
  logic        tirq_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        sel;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  msrv32_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .dmaddr_in     (dmaddr_in),
    .dmdata_in     (dmdata_in),
    .dmwr_req_in   (dmwr_req_in),
    .dmwr_mask_in  (dmwr_mask_in),
    .rdata_out     (rdata_out),
    .sel_out       (sel_out),
    .real_time_out (real_time_out),
    .tirq_out      (tirq_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One bus cycle; when chk is set the expected read result is queued and
  // compared against the DUT output one cycle later.
  task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] data,
                     input logic [3:0] mask, input logic chk, input logic [31:0] exp_rd,
                     input string tag);
    rd_exp_t e;
    dmaddr_in    = addr;
    dmwr_req_in  = we;
    dmdata_in    = data;
    dmwr_mask_in = mask;
    if (chk) begin
      e.tag   = tag;
      e.rdata = exp_rd;
      e.sel   = (addr[31:5] == BASE[31:5]);
      exp_q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    dmwr_req_in  = 1'b0;
    dmaddr_in    = IDLE_ADDR;
    dmwr_mask_in = '0;
    if (chk) begin
      e = exp_q.pop_front();
      check({e.tag, ".rdata"}, {32'd0, rdata_out}, {32'd0, e.rdata});
      check({e.tag, ".sel"}, {63'd0, sel_out}, {63'd0, e.sel});
    end
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data, input logic [3:0] mask);
    bus(BASE + {27'd0, off}, 1'b1, data, mask, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus(addr, 1'b0, 32'd0, 4'd0, 1'b1, exp, tag);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick_clk(3);
    check("rst.mtime", real_time_out, 64'd0);
    check("rst.tirq", {63'd0, tirq_out}, 64'd0);
    check("rst.rdata", {32'd0, rdata_out}, 64'd0);
    check("rst.sel", {63'd0, sel_out}, 64'd0);
    rst_in = 1'b0;

    // Free-running with div=0
    tick_clk(5);
    check("idle5.mtime", real_time_out, 64'd5);
    check("idle5.tirq", {63'd0, tirq_out}, 64'd0);
    check("idle5.rdata", {32'd0, rdata_out}, 64'd0);

    // div=3 via byte 1 only, then zero mtime: one tick per 4 cycles
    wr(5'h10, 32'h0000_0300, 4'b0010);
    wr(5'h00, 32'h0000_0000, 4'b1111);
    check("div3.start", real_time_out, 64'd0);
    tick_clk(38);
    check("div3.39cyc", real_time_out, 64'd9);
    tick_clk(1);
    check("div3.40cyc", real_time_out, 64'd10);

    // Carry from low into high word
    wr(5'h10, 32'h0000_0000, 4'b1111);
    wr(5'h04, 32'h0000_0000, 4'b1111);
    wr(5'h00, 32'hFFFF_FFFE, 4'b1111);
    wr(5'h10, 32'h0000_0001, 4'b0001);
    check("carry.pre", real_time_out, 64'h0000_0000_FFFF_FFFE);
    tick_clk(2);
    check("carry.post", real_time_out, 64'h0000_0001_0000_0000);
    tick_clk(3);
    check("carry.run", real_time_out, 64'h0000_0001_0000_0003);
    wr(5'h00, 32'hAABB_CC00, 4'b0001);
    check("collide.byte0", real_time_out, 64'h0000_0001_0000_0000);
    tick_clk(1);
    check("collide.resume", real_time_out, 64'h0000_0001_0000_0001);

    // Interrupt at mtimecmp=20
    wr(5'h10, 32'h0000_0000, 4'b1111);
    wr(5'h04, 32'h0000_0000, 4'b1111);
    wr(5'h00, 32'h0000_0000, 4'b1111);
    wr(5'h08, 32'd20, 4'b1111);
    wr(5'h0C, 32'h0000_0000, 4'b1111);
    check("cmp.armed.tirq", {63'd0, tirq_out}, 64'd0);
    wr(5'h10, 32'h0000_0001, 4'b0001);
    tick_clk(19);
    check("cmp.19.mtime", real_time_out, 64'd19);
    check("cmp.19.tirq", {63'd0, tirq_out}, 64'd0);
    tick_clk(1);
    check("cmp.20.mtime", real_time_out, 64'd20);
    check("cmp.20.tirq", {63'd0, tirq_out}, 64'd0);
    tick_clk(1);
    check("cmp.21.tirq", {63'd0, tirq_out}, 64'd1);
    wr(5'h0C, 32'h0000_0001, 4'b1111);
    check("cmp.raise.tirq_hold", {63'd0, tirq_out}, 64'd1);
    tick_clk(1);
    check("cmp.raise.tirq_fall", {63'd0, tirq_out}, 64'd0);

    // Read port: latency, map, window edges, reserved words
    wr(5'h10, 32'h0000_0000, 4'b1111);
    wr(5'h0C, 32'hFFFF_FFFF, 4'b1111);
    wr(5'h00, 32'h1234_5678, 4'b1111);
    wr(5'h10, 32'hFFFF_5A00, 4'b1111);
    rd(BASE + 32'h00, 32'h1234_5678, "rd.mtime_lo");
    rd(BASE + 32'h0C, 32'hFFFF_FFFF, "rd.cmp_hi");
    rd(BASE + 32'h14, 32'h0000_0000, "rd.rsvd14");
    rd(BASE + 32'h20, 32'h0000_0000, "rd.outside");
    rd(BASE + 32'h08, 32'd20,        "rd.cmp_lo");
    rd(BASE + 32'h10, 32'h0000_5A00, "rd.ctrl");
    rd(BASE + 32'h04, 32'h0000_0000, "rd.mtime_hi");
    rd(BASE + 32'h03, 32'h1234_5678, "rd.lowbits");
    bus(BASE + 32'h08, 1'b1, 32'h0000_0099, 4'b1111, 1'b1, 32'd20, "rd.same_cycle_old");
    rd(BASE + 32'h08, 32'h0000_0099, "rd.after_write");
    wr(5'h18, 32'hDEAD_BEEF, 4'b1111);
    rd(BASE + 32'h18, 32'h0000_0000, "rd.rsvd18");

    // 64-bit wrap
    wr(5'h04, 32'hFFFF_FFFF, 4'b1111);
    wr(5'h00, 32'hFFFF_FFFF, 4'b1111);
    wr(5'h10, 32'h0000_0001, 4'b1111);
    check("wrap.pre", real_time_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap.pre.tirq", {63'd0, tirq_out}, 64'd1);
    tick_clk(1);
    check("wrap.zero", real_time_out, 64'd0);
    check("wrap.zero.tirq", {63'd0, tirq_out}, 64'd1);
    tick_clk(1);
    check("wrap.one", real_time_out, 64'd1);
    check("wrap.one.tirq", {63'd0, tirq_out}, 64'd0);

    // Reset with a store pending in the same cycle
    dmaddr_in    = BASE;
    dmdata_in    = 32'h0000_5555;
    dmwr_mask_in = 4'b1111;
    dmwr_req_in  = 1'b1;
    rst_in       = 1'b1;
    tick_clk(1);
    rst_in       = 1'b0;
    dmwr_req_in  = 1'b0;
    dmaddr_in    = IDLE_ADDR;
    dmwr_mask_in = '0;
    check("mrst.mtime", real_time_out, 64'd0);
    check("mrst.sel", {63'd0, sel_out}, 64'd0);
    check("mrst.rdata", {32'd0, rdata_out}, 64'd0);
    rd(BASE + 32'h08, 32'hFFFF_FFFF, "mrst.cmp_lo");
    rd(BASE + 32'h10, 32'h0000_0001, "mrst.ctrl");
    check("mrst.count", real_time_out, 64'd2);
    check("mrst.tirq", {63'd0, tirq_out}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
